// File: rtl/banked_sram_ctrl.sv
// banked_sram_ctrl: request front-end over NUM_BANKS single-port SRAM banks.
// Single-beat writes and read bursts (1..MAX_BURST beats) are issued one beat
// per cycle, pass through a one-stage SRAM read pipeline and land in a
// 4-entry response FIFO.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_we, req_addr, req_len,    write flag, start word address, beats-1,
//   req_wdata                     write data
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata, rsp_err, rsp_last  read data, out-of-range bank, final beat
//   dbg_burst                     1 while the FSM is in BURST
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and the payload is stable while
// valid is high and not yet accepted.
module banked_sram_ctrl #(
  parameter int DATA_W    = 8,
  parameter int BANK_AW   = 10,
  parameter int NUM_BANKS = 278,
  parameter int ADDR_W    = 19,
  parameter int MAX_BURST = 16,
  localparam int LEN_W    = $clog2(MAX_BURST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_last,
  output logic              dbg_burst
);

  localparam int BW    = ADDR_W - BANK_AW;
  localparam int DEPTH = 1 << BANK_AW;
  localparam logic [BW:0] NB = (BW+1)'(NUM_BANKS);

  typedef enum logic {IDLE, BURST} state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   rem_q;

  // Beat being issued this cycle
  logic               iss_valid, iss_we, iss_last, iss_err;
  logic [ADDR_W-1:0]  iss_addr;
  logic [BW-1:0]      iss_bank;
  logic [BANK_AW-1:0] iss_off;

  // SRAM read stage (beat issued in the previous cycle)
  logic               s1_valid_q, s1_we_q, s1_err_q, s1_last_q;
  logic [BW-1:0]      s1_bank_q;
  logic [DATA_W-1:0]  s1_rdata;
  logic [DATA_W-1:0]  bank_rd [NUM_BANKS];

  // Response FIFO
  logic [DATA_W-1:0]  fifo_data [4];
  logic               fifo_err  [4];
  logic               fifo_last [4];
  logic [1:0]         wr_ptr_q, rd_ptr_q;
  logic [2:0]         cnt_q;
  logic [2:0]         credit;
  logic               credit_ok, push, pop;

  // Credit uses registered state only, so a pop frees issue one cycle later.
  assign credit    = cnt_q + {2'b00, s1_valid_q};
  assign credit_ok = credit < 3'd4;
  assign req_ready = !rst && (state_q == IDLE) && credit_ok;
  assign dbg_burst = (state_q == BURST);

  always_comb begin
    iss_valid = 1'b0;
    iss_we    = 1'b0;
    iss_last  = 1'b0;
    iss_addr  = addr_q;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (req_valid && credit_ok) begin
            iss_valid = 1'b1;
            iss_addr  = req_addr;
            iss_we    = req_we;
            iss_last  = req_we || (req_len == '0);
          end
        end
        BURST: begin
          if (credit_ok) begin
            iss_valid = 1'b1;
            iss_last  = (rem_q == LEN_W'(1));
          end
        end
        default: ;
      endcase
    end
  end

  assign iss_bank = iss_addr[ADDR_W-1:BANK_AW];
  assign iss_off  = iss_addr[BANK_AW-1:0];
  assign iss_err  = {1'b0, iss_bank} >= NB;

  // Control FSM; rem_q counts beats still to issue after the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (iss_valid && !req_we && (req_len != '0)) begin
            state_q <= BURST;
            addr_q  <= req_addr + ADDR_W'(1);
            rem_q   <= req_len;
          end
        end
        BURST: begin
          if (iss_valid) begin
            addr_q <= addr_q + ADDR_W'(1);   // wraps at 2^ADDR_W naturally
            rem_q  <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Banks: only the selected, in-range bank sees an enable.
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic              sel;
    assign sel = iss_valid && !iss_err && (iss_bank == BW'(g));
    always_ff @(posedge clk) begin
      if (sel) begin
        if (iss_we) mem[iss_off] <= req_wdata;
        else        rd_q         <= mem[iss_off];
      end
    end
    assign bank_rd[g] = rd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_we_q    <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_bank_q  <= '0;
    end else begin
      s1_valid_q <= iss_valid;
      s1_we_q    <= iss_we;
      s1_err_q   <= iss_err;
      s1_last_q  <= iss_last;
      s1_bank_q  <= iss_bank;
    end
  end

  always_comb begin
    s1_rdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (s1_bank_q == BW'(b)) s1_rdata = bank_rd[b];
    end
    if (s1_we_q || s1_err_q) s1_rdata = '0;
  end

  assign push = s1_valid_q;
  assign pop  = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_q] <= s1_rdata;
      fifo_err[wr_ptr_q]  <= s1_err_q;
      fifo_last[wr_ptr_q] <= s1_last_q;
    end
  end

  // Outputs read as zero whenever the FIFO is empty.
  assign rsp_valid = (cnt_q != 3'd0);
  assign rsp_rdata = rsp_valid ? fifo_data[rd_ptr_q] : '0;
  assign rsp_err   = rsp_valid && fifo_err[rd_ptr_q];
  assign rsp_last  = rsp_valid && fifo_last[rd_ptr_q];

endmodule

// File: tb/tb_banked_sram_ctrl.sv
module tb_banked_sram_ctrl;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [18:0] req_addr = '0;
  logic [3:0]  req_len = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        rsp_last;
  logic        dbg_burst;

  banked_sram_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_last  (rsp_last),
    .dbg_burst (dbg_burst)
  );

  int checks = 0;
  int errors = 0;
  int beats_seen = 0;
  int rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // rsp_ready driver
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- behavioural model + scoreboard ----------------
  // exp_q entry: {known, err, last, data[7:0]}
  logic [7:0]  mem_m [int];
  logic [10:0] exp_q [$];

  function automatic void model_accept(input logic we, input logic [18:0] a,
                                       input logic [3:0] len, input logic [7:0] wd);
    logic [18:0] aa;
    logic        err, known;
    logic [7:0]  d;
    if (we) begin
      err = (int'(a) / 1024) >= 278;
      if (!err) mem_m[int'(a)] = wd;
      exp_q.push_back({1'b1, err, 1'b1, 8'h00});
    end else begin
      for (int i = 0; i <= int'(len); i++) begin
        aa    = a + 19'(i);
        err   = (int'(aa) / 1024) >= 278;
        known = err || mem_m.exists(int'(aa));
        d     = (err || !known) ? 8'h00 : mem_m[int'(aa)];
        exp_q.push_back({known, err, (i == int'(len)), d});
      end
    end
  endfunction

  always @(negedge clk) begin
    logic [10:0] e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q[0];
          chk("sb_err", 32'(rsp_err), 32'(e[9]));
          chk("sb_last", 32'(rsp_last), 32'(e[8]));
          if (e[10]) chk("sb_rdata", 32'(rsp_rdata), 32'(e[7:0]));
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            beats_seen++;
          end
        end
      end
      if (req_valid && req_ready) model_accept(req_we, req_addr, req_len, req_wdata);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic do_req(input logic we, input logic [18:0] a, input logic [3:0] len,
                        input logic [7:0] wd);
    bit acc = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_len   = len;
    req_wdata = wd;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      if (req_ready) acc = 1;
    end
    chk("req_accept", 32'(acc), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) done = 1;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    #1;
  endtask

  logic [18:0] bases [4] = '{19'h00000, 19'h003F0, 19'h457E0, 19'h7FFE0};

  // ---------------- test sequence ----------------
  initial begin
    int snap, vcnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("post_rst_err", 32'(rsp_err), 32'd0);
    chk("post_rst_last", 32'(rsp_last), 32'd0);

    // Write 0xA5 @0x400 then read it back the next cycle
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 19'h00400; req_wdata = 8'hA5; req_len = '0;
    @(negedge clk);
    chk("wr_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_we = 1'b0;
    @(negedge clk);
    chk("wr_not_early", 32'(rsp_valid), 32'd0);
    chk("rd_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("wr_rsp_last", 32'(rsp_last), 32'd1);
    @(negedge clk);
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_rdata", 32'(rsp_rdata), 32'hA5);
    chk("rd_rsp_last", 32'(rsp_last), 32'd1);
    @(posedge clk); #1;

    // Bank crossing read
    do_req(1'b1, 19'h003FF, 4'd0, 8'h11);
    do_req(1'b1, 19'h00400, 4'd0, 8'h22);
    drain();
    do_req(1'b0, 19'h003FF, 4'd1, 8'h00);
    @(negedge clk);
    chk("x_not_early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("x_b0_valid", 32'(rsp_valid), 32'd1);
    chk("x_b0_rdata", 32'(rsp_rdata), 32'h11);
    chk("x_b0_last", 32'(rsp_last), 32'd0);
    @(negedge clk);
    chk("x_b1_valid", 32'(rsp_valid), 32'd1);
    chk("x_b1_rdata", 32'(rsp_rdata), 32'h22);
    chk("x_b1_last", 32'(rsp_last), 32'd1);
    drain();

    // Out-of-range bank 278
    do_req(1'b0, 19'h45800, 4'd0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("oor_valid", 32'(rsp_valid), 32'd1);
    chk("oor_err", 32'(rsp_err), 32'd1);
    chk("oor_rdata", 32'(rsp_rdata), 32'd0);
    chk("oor_last", 32'(rsp_last), 32'd1);
    drain();

    // Prefill the address windows used below
    rdy_mode = 2;
    for (int w = 0; w < 4; w++)
      for (int i = 0; i < 48; i++)
        do_req(1'b1, bases[w] + 19'(i), 4'd0, 8'($urandom));
    drain();

    // Credit stall with rsp_ready low
    @(negedge clk); rdy_mode = 0;
    repeat (2) @(posedge clk); #1;
    snap = beats_seen;
    do_req(1'b0, 19'h00000, 4'd15, 8'h00);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("stall_req_ready", 32'(req_ready), 32'd0);
    chk("stall_in_burst", 32'(dbg_burst), 32'd1);
    chk("stall_no_pop", 32'(beats_seen - snap), 32'd0);
    rdy_mode = 1;
    drain();
    chk("stall_total_beats", 32'(beats_seen - snap), 32'd16);

    // Reset during beat 5 of a 16-beat burst
    do_req(1'b0, 19'h00000, 4'd15, 8'h00);
    repeat (4) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_burst", 32'(dbg_burst), 32'd0);
    chk("mid_rst_rdata", 32'(rsp_rdata), 32'd0);
    vcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) vcnt++;
    end
    chk("mid_rst_no_beats", 32'(vcnt), 32'd0);
    @(posedge clk); #1;

    // Randomized traffic
    rdy_mode = 2;
    for (int n = 0; n < 150; n++) begin
      do_req(($urandom_range(0, 2) == 0),
             bases[$urandom_range(0, 3)] + 19'($urandom_range(0, 47)),
             4'($urandom_range(0, 15)), 8'($urandom));
    end
    @(negedge clk); rdy_mode = 1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/banked_sram_ctrl.md
BANKED_SRAM_CTRL -- requirements
Module: banked_sram_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data word width in bits.
REQ-002 Parameter BANK_AW, default 10, SHALL set the per-bank address width (bank depth 2^BANK_AW).
REQ-003 Parameter NUM_BANKS, default 278, SHALL set the number of instantiated SRAM banks.
REQ-004 Parameter ADDR_W, default 19, SHALL set the request address width; NUM_BANKS*2^BANK_AW <= 2^ADDR_W SHALL hold.
REQ-005 Parameter MAX_BURST, default 16, a power of two, SHALL set the maximum read burst length; LEN_W = log2(MAX_BURST).
REQ-006 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 rst  input  1  SHALL be the reset, synchronous, active-high.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  request accepted when high with req_valid.
REQ-010 req_we  input  1  1 = single-beat write, 0 = read burst.
REQ-011 req_addr  input  ADDR_W  start word address.
REQ-012 req_len  input  LEN_W  read beats minus one; ignored for writes.
REQ-013 req_wdata  input  DATA_W  write data.
REQ-014 rsp_valid  output  1  response beat present.
REQ-015 rsp_ready  input  1  response beat consumed when high with rsp_valid.
REQ-016 rsp_rdata  output  DATA_W  read data; 0 for writes and error beats.
REQ-017 rsp_err  output  1  beat addressed bank >= NUM_BANKS.
REQ-018 rsp_last  output  1  final beat of a request.

Function
REQ-019 Address split SHALL be bank = addr[ADDR_W-1:BANK_AW], offset = addr[BANK_AW-1:0].
REQ-020 Each bank SHALL be a DATA_W x 2^BANK_AW single-port SRAM with one-cycle registered read; write enable reaches only the selected bank.
REQ-021 Beats with bank >= NUM_BANKS SHALL NOT enable any bank and SHALL respond rsp_err=1, rsp_rdata=0.
REQ-022 FSM states IDLE, BURST; req_ready SHALL be 1 only in IDLE with credit available (REQ-027), never in BURST.
REQ-023 IDLE, accepted write: beat issued that cycle, bank written at the next edge, one response (rdata 0, last 1); FSM stays IDLE.
REQ-024 IDLE, accepted read: first beat issued that cycle; req_len=0 stays IDLE with last=1, else go to BURST with remaining = req_len.
REQ-025 BURST: one beat per cycle while credit available, address +1 per beat, crossing bank boundaries (offset 2^BANK_AW-1 -> 0, bank+1); address 2^ADDR_W-1 SHALL wrap to 0; final beat carries last=1 and returns FSM to IDLE.
REQ-026 Beat issued in cycle t SHALL appear at rsp_valid no earlier than cycle t+2 and exactly t+2 when the output FIFO is empty; responses SHALL be in issue order.
REQ-027 Output FIFO depth 4; credit = FIFO occupancy + beats in flight; a beat SHALL issue only when credit < 4, so no response is ever dropped.
REQ-028 Simultaneous FIFO push and pop SHALL leave occupancy unchanged; rsp_valid deasserts only when the FIFO is empty.
REQ-029 Write followed by read of the same address in the next cycle SHALL return the new data.
REQ-030 Credit exhaustion mid-burst SHALL stall issue without losing address or remaining count; issue resumes in the cycle after credit frees.

Reset
REQ-031 While rst is high at an edge: FSM -> IDLE, FIFO empty, in-flight beats discarded, burst count and address cleared.
REQ-032 Outputs after reset: rsp_valid 0, rsp_rdata 0, rsp_err 0, rsp_last 0, req_ready 0 during rst, 1 in the first cycle after rst deasserts.
REQ-033 Reset mid-burst SHALL abort remaining beats with no further responses; SRAM contents SHALL NOT be reset.

Verification
REQ-034 Write 0xA5 to addr 0x00400, then read len 0 at 0x00400, rsp_ready=1 -> write rsp (rdata 0, last 1), read rsp rdata 0xA5, last 1, exactly 2 cycles after issue.
REQ-035 Write 0x11 to 0x003FF and 0x22 to 0x00400, read len 1 from 0x003FF -> beats 0x11 then 0x22 on consecutive cycles, last only on second (bank crossing).
REQ-036 Read len 0 at bank 278 (addr 0x45800) -> rsp_err 1, rdata 0, last 1; no bank write/read enable observed.
REQ-037 Read len 15 with rsp_ready held 0 -> exactly 4 beats buffered, issue stalls, req_ready 0; release rsp_ready -> all 16 beats in order, last on 16th.
REQ-038 Assert rst for one cycle during beat 5 of a 16-beat burst -> rsp_valid 0 next cycle, no later beats, req_ready 1 the cycle after rst drops.
